// File: rtl/fetch.sv
// fetch: IF stage holding the PC, choosing the next PC and capturing redirects raised while stalled.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0034
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_valid,
  input  logic        next_fetch,
  input  logic [31:0] inst,
  input  logic [32:0] jbr_bus,
  input  logic [32:0] exc_bus,
  input  logic        cancel,
  output logic [31:0] inst_addr,
  output logic        IF_over,
  output logic [63:0] IF_ID_bus,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);
  logic [31:0] pc_q, pc_d, pend_pc_q, jbr_target, exc_pc;
  logic        pend_valid_q, pend_exc_q, ready_q, jbr_taken, exc_valid;
  assign jbr_taken  = jbr_bus[32];
  assign jbr_target = jbr_bus[31:0] & 32'hFFFF_FFFC;
  assign exc_valid  = exc_bus[32];
  assign exc_pc     = exc_bus[31:0] & 32'hFFFF_FFFC;
  always_comb
    pc_d = exc_valid    ? exc_pc    :
           pend_valid_q ? pend_pc_q :
           jbr_taken    ? jbr_target : pc_q + 32'd4;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_exc_q   <= 1'b0;
      pend_pc_q    <= 32'd0;
      ready_q      <= 1'b0;
    end else if (next_fetch) begin
      pc_q         <= pc_d;
      pend_valid_q <= 1'b0;
      pend_exc_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      // a captured exception can only be displaced by a newer exception
      if (exc_valid) begin
        pend_valid_q <= 1'b1;
        pend_exc_q   <= 1'b1;
        pend_pc_q    <= exc_pc;
      end else if (jbr_taken && !(pend_valid_q && pend_exc_q)) begin
        pend_valid_q <= 1'b1;
        pend_exc_q   <= 1'b0;
        pend_pc_q    <= jbr_target;
      end
      if (IF_valid) ready_q <= 1'b1;
    end
  end
  assign inst_addr = pc_q;
  assign IF_pc     = pc_q;
  assign IF_inst   = inst;
  assign IF_ID_bus = {pc_q, inst};
  assign IF_over   = IF_valid & ready_q & ~cancel;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed plan scenarios plus random traffic checked against a queue-based redirect model.
module tb_fetch;
  logic        clk = 1'b0, resetn = 1'b0, IF_valid = 1'b0, next_fetch = 1'b0, cancel = 1'b0;
  logic [31:0] inst = 32'd0, inst_addr, IF_pc, IF_inst;
  logic [32:0] jbr_bus = 33'd0, exc_bus = 33'd0;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  int          n_vec = 0, n_bad = 0;
  typedef struct packed {logic exc; logic [31:0] addr;} redir_t;
  redir_t      pend[$];
  logic [31:0] m_pc;
  logic        m_rdy, m_known = 1'b0;

  fetch dut (
    .clk(clk), .resetn(resetn), .IF_valid(IF_valid), .next_fetch(next_fetch), .inst(inst),
    .jbr_bus(jbr_bus), .exc_bus(exc_bus), .cancel(cancel), .inst_addr(inst_addr),
    .IF_over(IF_over), .IF_ID_bus(IF_ID_bus), .IF_pc(IF_pc), .IF_inst(IF_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive, check combinational view against the model, then advance the model
  task automatic cyc(input logic rn, input logic nf, input logic iv, input logic cn,
                     input logic [32:0] jb, input logic [32:0] eb);
    logic [31:0] tgt;
    @(negedge clk);
    resetn = rn; next_fetch = nf; IF_valid = iv; cancel = cn; jbr_bus = jb; exc_bus = eb;
    inst = $urandom;
    #1;
    if (m_known) begin
      chk("inst_addr", {32'd0, inst_addr}, {32'd0, m_pc});
      chk("IF_pc", {32'd0, IF_pc}, {32'd0, m_pc});
      chk("IF_over", {63'd0, IF_over}, {63'd0, iv & m_rdy & ~cn});
      chk("IF_ID_bus", IF_ID_bus, {m_pc, inst});
      chk("IF_inst", {32'd0, IF_inst}, {32'd0, inst});
    end
    @(posedge clk);
    if (!rn) begin
      m_pc = 32'h34; pend.delete(); m_rdy = 1'b0; m_known = 1'b1;
    end else if (nf) begin
      if (eb[32]) tgt = eb[31:0];
      else if (pend.size() != 0) tgt = pend[0].addr;
      else if (jb[32]) tgt = jb[31:0];
      else tgt = m_pc + 32'd4;
      m_pc = {tgt[31:2], 2'b00};
      pend.delete();
      m_rdy = 1'b0;
    end else begin
      if (eb[32]) begin
        pend.delete(); pend.push_back('{1'b1, {eb[31:2], 2'b00}});
      end else if (jb[32] && !(pend.size() != 0 && pend[0].exc)) begin
        pend.delete(); pend.push_back('{1'b0, {jb[31:2], 2'b00}});
      end
      if (iv) m_rdy = 1'b1;
    end
  endtask

  initial begin
    // plan 1: reset held with next_fetch, then sequential fetch
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("post_reset_over", {63'd0, IF_over}, 64'd0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("ready_over", {63'd0, IF_over}, 64'd1);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("seq_pc", {32'd0, inst_addr}, 64'h38);
    cyc(1, 0, 1, 0, 0, 0);
    // plan 2: branch from 0x40
    cyc(1, 1, 1, 0, {1'b1, 32'h40}, 0);
    cyc(1, 1, 1, 0, {1'b1, 32'h100}, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("br_bus_pc", {32'd0, IF_ID_bus[63:32]}, 64'h100);
    // plan 3: exception and branch together with cancel
    cyc(1, 1, 1, 1, {1'b1, 32'h200}, {1'b1, 32'h0});
    cyc(1, 0, 1, 0, 0, 0);
    chk("exc_pc", {32'd0, inst_addr}, 64'h0);
    // plan 4: pending exception beats later branch
    cyc(1, 0, 1, 0, 0, {1'b1, 32'h500});
    cyc(1, 0, 1, 0, {1'b1, 32'h600}, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("pend_cleared", {32'd0, inst_addr}, 64'h504);
    // plan 5: pending branch consumed
    cyc(1, 0, 1, 0, {1'b1, 32'h300}, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("pend_br_seq", {32'd0, inst_addr}, 64'h304);
    // plan 6: alignment and wrap
    cyc(1, 1, 1, 0, {1'b1, 32'hFFFF_FFFF}, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("wrap", {32'd0, inst_addr}, 64'h0);
    // reset mid-stall drops a pending redirect
    cyc(1, 0, 1, 0, {1'b1, 32'h700}, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("reset_drop", {32'd0, inst_addr}, 64'h38);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 40) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0,
          {$urandom_range(0, 3) == 0, 32'($urandom)},
          {$urandom_range(0, 7) == 0, 32'($urandom)});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- IF stage of the 5-stage pipeline; the receiving end of the `exc_bus`/`cancel` redirect interface driven by the write-back stage.
- Holds the PC and drives the instruction ROM address.
- Selects the next PC from four sources: exception/ERET redirect, pending redirect, branch/jump redirect, sequential PC+4.
- Reports instruction completion to pipeline control and produces the IF->ID bus.

Parameters:
- RESET_PC, 32'h0000_0034, PC loaded on reset. Must differ from the exception entry 0x0.

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  synchronous reset, active low
- IF_valid  input  1  IF stage holds a valid instruction
- next_fetch  input  1  pipeline control permits loading a new PC this cycle
- inst  input  32  instruction ROM read data; valid 1 cycle after address change
- jbr_bus  input  33  {jbr_taken, jbr_target[31:0]} from decode
- exc_bus  input  33  {exc_valid, exc_pc[31:0]} from write-back
- cancel  input  1  write-back flush (syscall/eret)
- inst_addr  output  32  instruction ROM address
- IF_over  output  1  IF instruction complete
- IF_ID_bus  output  64  {pc, inst} to decode
- IF_pc  output  32  current PC, for display
- IF_inst  output  32  current instruction, for display

Behaviour:
Reset:
- resetn=0 sampled at posedge: pc<=RESET_PC, pend_valid<=0, pend_exc<=0, pend_pc<=0, ready<=0.
- Reset overrides next_fetch, exc_bus and jbr_bus.
- Outputs after reset: inst_addr=RESET_PC, IF_over=0.

PC register:
- inst_addr = IF_pc = pc.
- pc[1:0] is always 2'b00; low 2 bits of every redirect target are forced to 0.

Next-PC priority when next_fetch=1 (highest first):
1. exc_valid: exc_pc
2. pend_valid: pend_pc
3. jbr_taken: jbr_target
4. otherwise: pc+4, 32-bit wrap, so 0xFFFF_FFFC -> 0x0000_0000

- pc loads the selected value at the posedge.
- pend_valid and pend_exc clear on any next_fetch=1, whether the pending redirect is consumed or superseded.

Pending-redirect register (captures redirects while the PC is stalled, next_fetch=0):
- exc_valid=1: pend_valid<=1, pend_exc<=1, pend_pc<=exc_pc. Always overwrites, including a pending jbr or an older exception.
- else jbr_taken=1 and (pend_valid=0 or pend_exc=0): pend_valid<=1, pend_exc<=0, pend_pc<=jbr_target. A newer jbr overwrites an older jbr.
- jbr_taken=1 while pend_exc=1: ignored. The exception wins.
- Otherwise: hold.

ROM-latency tracker `ready`:
- next_fetch=1: ready<=0, because the new address is not yet read.
- else IF_valid=1: ready<=1.
- else: hold.

Completion:
- IF_over = IF_valid & ready & ~cancel.
- Minimum latency: PC load -> IF_over=1 is two cycles later (one ROM cycle, one ready cycle).
- While IF_valid=1, next_fetch=0 and no cancel, IF_over stays high; inst is stable because the address is unchanged.

Cancel:
- cancel=1 forces IF_over=0 that cycle.
- The PC is not changed by cancel itself. The redirect arrives via exc_valid in the same cycle and follows the rules above.

Outputs:
- IF_ID_bus = {pc, inst}; IF_inst = inst.
- Values are meaningful only when IF_over=1. Decode must qualify them.

Boundary conditions:
- exc_valid and jbr_taken in the same cycle with next_fetch=1: exc_pc wins; jbr is discarded and not captured.
- exc_valid and next_fetch=1 while pend_valid=1: exc_pc wins; pending is cleared.
- resetn low mid-stall with a pending redirect: pending is lost; pc=RESET_PC.
- next_fetch=1 on consecutive cycles: pc advances each cycle; IF_over stays 0 (ready never sets).

Test Plan:
1. Reset, then sequential fetch:
   - Stimulus: resetn=0 for 2 cycles with next_fetch=1; release; IF_valid=1, next_fetch=0.
   - Required: pc=0x34 during and after reset; IF_over=0 in the first post-reset cycle, 1 from the next cycle onward.
   - Then pulse next_fetch for one cycle: pc=0x38; IF_over=0 for one cycle, then 1.
2. Branch redirect:
   - Stimulus: pc=0x40, jbr_bus={1,0x0000_0100}, next_fetch=1.
   - Required: pc=0x100 next cycle; IF_ID_bus[63:32]=0x100 when IF_over=1.
3. Simultaneous exception and branch:
   - Stimulus: exc_bus={1,0x0}, jbr_bus={1,0x200}, next_fetch=1, cancel=1.
   - Required: IF_over=0 that cycle; pc=0x0 next cycle.
4. Pending exception beats a later branch:
   - Stimulus: next_fetch=0; exc_bus={1,0x0000_0500} one cycle; next cycle jbr_bus={1,0x600}; then next_fetch=1 with no live redirect.
   - Required: pc=0x500; pend_valid=0 afterwards.
5. Pending branch consumed:
   - Stimulus: next_fetch=0; jbr_bus={1,0x300} one cycle; two idle cycles; next_fetch=1.
   - Required: pc=0x300. A following next_fetch gives pc=0x304.
6. Wrap and alignment:
   - Stimulus: jbr target 0xFFFF_FFFF loaded via next_fetch, then next_fetch again.
   - Required: pc=0xFFFF_FFFC, then pc=0x0000_0000.
